// File: rtl/board_pkg.sv
// Shared types and sizing helpers for the N x N board move controller.
package board_pkg;

  localparam int unsigned ERR_W = 3;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE      = 3'd0,
    ERR_OCCUPIED  = 3'd1,
    ERR_RANGE     = 3'd2,
    ERR_PLAYER    = 3'd3,
    ERR_GAME_OVER = 3'd4,
    ERR_TURN      = 3'd5
  } move_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

  // Row/column index width for an n x n board.
  function automatic int unsigned rw_of(input int unsigned n);
    return $clog2(n);
  endfunction

  // Width of a filled-cell counter that can reach n*n.
  function automatic int unsigned cw_of(input int unsigned n);
    return $clog2(n * n + 1);
  endfunction

  // Rows, columns and both diagonals.
  function automatic int unsigned lines_of(input int unsigned n);
    return 2 * n + 2;
  endfunction

  function automatic int unsigned lw_of(input int unsigned n);
    return $clog2(2 * n + 2);
  endfunction

endpackage

// File: rtl/board_move_ctrl_line_check.sv
// Combinational line evaluator: maps a scan line index onto its N board cells
// and reports whether they all hold the same nonzero player id.
module board_line_check
  import board_pkg::*;
#(
  parameter  int unsigned N  = 3,
  parameter  int unsigned PW = 2,
  localparam int unsigned BW = N * N * PW,
  localparam int unsigned LW = lw_of(N)
) (
  input  logic [BW-1:0] i_board,
  input  logic [LW-1:0] i_line,
  output logic          o_line_win_c,
  output logic [PW-1:0] o_line_val_c
);

  // Cell k of line l: rows, then columns, then main and anti diagonal.
  function automatic logic [PW-1:0] cell_at(input logic [BW-1:0] b,
                                            input int unsigned l,
                                            input int unsigned k);
    int unsigned r;
    int unsigned c;
    if (l < N) begin
      r = l;
      c = k;
    end else if (l < 2 * N) begin
      r = k;
      c = l - N;
    end else if (l == 2 * N) begin
      r = k;
      c = k;
    end else begin
      r = k;
      c = N - 1 - k;
    end
    return PW'(b >> ((r * N + c) * PW));
  endfunction

  always_comb begin
    o_line_val_c = cell_at(i_board, 32'(i_line), 0);
    o_line_win_c = (o_line_val_c != '0);
    for (int unsigned k = 1; k < N; k++) begin
      if (cell_at(i_board, 32'(i_line), k) != o_line_val_c) o_line_win_c = 1'b0;
    end
  end

endmodule

// File: rtl/board_move_ctrl.sv
// N x N board owner: validates and writes moves over a req/done handshake,
// then scans one line per cycle for a win or draw. Optional: TURN_ORDER_EN.
module board_move_ctrl
  import board_pkg::*;
#(
  parameter  int unsigned N           = 3,
  parameter  int unsigned PW          = 2,
  parameter  int unsigned NUM_PLAYERS = 2,
  localparam int unsigned RW          = rw_of(N),
  localparam int unsigned CW          = cw_of(N),
  localparam int unsigned BW          = N * N * PW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              move_req,
  input  logic [PW-1:0]     move_player,
  input  logic [RW-1:0]     move_row,
  input  logic [RW-1:0]     move_col,
  output logic              move_done,
  output logic              move_ok,
  output logic [ERR_W-1:0]  move_err,
  output logic              busy,
  output logic [BW-1:0]     board,
  output logic [CW-1:0]     move_count,
  output logic              full,
  output logic [PW-1:0]     winner,
  output logic              game_over,
  output logic [PW-1:0]     next_player
);

  localparam int unsigned LW    = lw_of(N);
  localparam int unsigned LINES = lines_of(N);

`ifdef TURN_ORDER_EN
  localparam logic [PW-1:0] NP_INIT = PW'(1);
`else
  localparam logic [PW-1:0] NP_INIT = '0;
`endif

  state_e          r_state, w_state;
  logic [BW-1:0]   r_board, w_board;
  logic [CW-1:0]   r_count, w_count;
  logic [PW-1:0]   r_winner, w_winner;
  logic            r_go, w_go;
  logic [PW-1:0]   r_np, w_np;
  logic [LW-1:0]   r_line, w_line;
  logic            r_done, w_done;
  logic            r_ok, w_ok;
  move_err_e       r_err, w_err;
  logic            r_busy, w_busy;
  logic            r_full, w_full;

  logic            w_player_bad;
  logic            w_range_bad;
  logic            w_turn_bad;
  int unsigned     w_idx;
  logic [PW-1:0]   w_cell;
  logic [BW-1:0]   w_mask;
  logic [BW-1:0]   w_wdata;
  move_err_e       w_req_err;
  logic            w_line_win;
  logic [PW-1:0]   w_line_val;

  board_line_check #(
    .N  (N),
    .PW (PW)
  ) u_line_check (
    .i_board      (r_board),
    .i_line       (r_line),
    .o_line_win_c (w_line_win),
    .o_line_val_c (w_line_val)
  );

  // Request decode; the cell index is forced to 0 when out of range.
  assign w_player_bad = (move_player == '0) || (32'(move_player) > NUM_PLAYERS);
  assign w_range_bad  = (32'(move_row) >= N) || (32'(move_col) >= N);
  assign w_idx        = w_range_bad ? 0 : (32'(move_row) * N + 32'(move_col));
  assign w_cell       = PW'(r_board >> (w_idx * PW));
  assign w_mask       = BW'({PW{1'b1}}) << (w_idx * PW);
  assign w_wdata      = BW'(move_player) << (w_idx * PW);

`ifdef TURN_ORDER_EN
  assign w_turn_bad = (move_player != r_np);
`else
  assign w_turn_bad = 1'b0;
`endif

  always_comb begin
    w_req_err = ERR_NONE;
    if (r_go)                 w_req_err = ERR_GAME_OVER;
    else if (w_player_bad)    w_req_err = ERR_PLAYER;
    else if (w_range_bad)     w_req_err = ERR_RANGE;
    else if (w_turn_bad)      w_req_err = ERR_TURN;
    else if (w_cell != '0)    w_req_err = ERR_OCCUPIED;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state  = r_state;
    w_board  = r_board;
    w_count  = r_count;
    w_winner = r_winner;
    w_go     = r_go;
    w_np     = r_np;
    w_line   = r_line;
    w_done   = 1'b0;
    w_ok     = r_ok;
    w_err    = r_err;

    if (clear) begin
      w_state  = ST_IDLE;
      w_board  = '0;
      w_count  = '0;
      w_winner = '0;
      w_go     = 1'b0;
      w_np     = NP_INIT;
      w_line   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (move_req) begin
            w_done  = 1'b1;
            w_state = ST_DONE;
            w_err   = w_req_err;
            w_ok    = (w_req_err == ERR_NONE);
            if (w_req_err == ERR_NONE) begin
              w_board = (r_board & ~w_mask) | w_wdata;
              if (r_count != CW'(N * N)) w_count = r_count + CW'(1);
`ifdef TURN_ORDER_EN
              w_np = (r_np == PW'(NUM_PLAYERS)) ? PW'(1) : r_np + PW'(1);
`endif
            end
          end
        end
        ST_DONE: begin
          w_line  = '0;
          w_state = r_ok ? ST_SCAN : ST_IDLE;
        end
        ST_SCAN: begin
          if (w_line_win) begin
            w_winner = w_line_val;
            w_go     = 1'b1;
            w_state  = ST_IDLE;
          end else if (r_line == LW'(LINES - 1)) begin
            // No line completed: a full board is a draw.
            if (r_full) begin
              w_winner = '0;
              w_go     = 1'b1;
            end
            w_state = ST_IDLE;
          end else begin
            w_line = r_line + LW'(1);
          end
        end
        default: w_state = ST_IDLE;
      endcase
    end

    w_busy = (w_state != ST_IDLE);
    w_full = (w_count == CW'(N * N));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_board  <= '0;
      r_count  <= '0;
      r_winner <= '0;
      r_go     <= 1'b0;
      r_np     <= NP_INIT;
      r_line   <= '0;
      r_done   <= 1'b0;
      r_ok     <= 1'b0;
      r_err    <= ERR_NONE;
      r_busy   <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_board  <= w_board;
      r_count  <= w_count;
      r_winner <= w_winner;
      r_go     <= w_go;
      r_np     <= w_np;
      r_line   <= w_line;
      r_done   <= w_done;
      r_ok     <= w_ok;
      r_err    <= w_err;
      r_busy   <= w_busy;
      r_full   <= w_full;
    end
  end

  assign move_done   = r_done;
  assign move_ok     = r_ok;
  assign move_err    = r_err;
  assign busy        = r_busy;
  assign board       = r_board;
  assign move_count  = r_count;
  assign full        = r_full;
  assign winner      = r_winner;
  assign game_over   = r_go;
  assign next_player = r_np;

endmodule

// File: tb/tb_board_move_ctrl.sv
// Bench for board_move_ctrl (3x3, two players); also builds with TURN_ORDER_EN.
module tb_board_move_ctrl;

  localparam int N  = 3;
  localparam int PW = 2;
  localparam int NP = 2;
  localparam int RW = 2;
  localparam int CW = 4;
  localparam int BW = N * N * PW;

`ifdef TURN_ORDER_EN
  localparam int NP_INIT = 1;
`else
  localparam int NP_INIT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          move_req = 1'b0;
  logic [PW-1:0] move_player = '0;
  logic [RW-1:0] move_row = '0;
  logic [RW-1:0] move_col = '0;
  logic          move_done;
  logic          move_ok;
  logic [2:0]    move_err;
  logic          busy;
  logic [BW-1:0] board;
  logic [CW-1:0] move_count;
  logic          full;
  logic [PW-1:0] winner;
  logic          game_over;
  logic [PW-1:0] next_player;

  board_move_ctrl #(.N(N), .PW(PW), .NUM_PLAYERS(NP)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .move_req    (move_req),
    .move_player (move_player),
    .move_row    (move_row),
    .move_col    (move_col),
    .move_done   (move_done),
    .move_ok     (move_ok),
    .move_err    (move_err),
    .busy        (busy),
    .board       (board),
    .move_count  (move_count),
    .full        (full),
    .winner      (winner),
    .game_over   (game_over),
    .next_player (next_player)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected-state model of the game.
  int m_board [N][N];
  int m_count, m_winner, m_go, m_np;
  bit exp_busy, exp_done, exp_ok;
  int exp_err;
  bit chk_en = 1'b0;

  // Values observed on the last move_done and the last busy run length.
  int cap_err, cap_ok;
  int run_len = 0, last_run = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] flat();
    logic [BW-1:0] f = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        f |= BW'(m_board[r][c]) << ((r * N + c) * PW);
    return f;
  endfunction

  function automatic int line_cell(input int l, input int k);
    if (l < N)          return m_board[l][k];
    else if (l < 2 * N) return m_board[k][l - N];
    else if (l == 2 * N) return m_board[k][k];
    return m_board[k][N - 1 - k];
  endfunction

  // First completed line in scan order, or -1.
  function automatic int first_win(output int val);
    val = 0;
    for (int l = 0; l < 2 * N + 2; l++) begin
      int v;
      bit same;
      v = line_cell(l, 0);
      same = (v != 0);
      for (int k = 1; k < N; k++) if (line_cell(l, k) != v) same = 1'b0;
      if (same) begin
        val = v;
        return l;
      end
    end
    return -1;
  endfunction

  function automatic int err_of(input int p, input int r, input int c);
    if (m_go != 0) return 4;
    if (p == 0 || p > NP) return 3;
    if (r >= N || c >= N) return 2;
`ifdef TURN_ORDER_EN
    if (p != m_np) return 5;
`endif
    if (m_board[r][c] != 0) return 1;
    return 0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) m_board[r][c] = 0;
    m_count = 0; m_winner = 0; m_go = 0; m_np = NP_INIT;
    exp_busy = 1'b0; exp_done = 1'b0;
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("board", board, flat());
      chk("move_count", move_count, m_count);
      chk("full", full, (m_count == N * N));
      chk("winner", winner, m_winner);
      chk("game_over", game_over, m_go);
      chk("busy", busy, exp_busy);
      chk("next_player", next_player, m_np);
      chk("move_done", move_done, exp_done);
      if (exp_done) begin
        chk("move_ok", move_ok, exp_ok);
        chk("move_err", move_err, exp_err);
      end
    end
    if (move_done) begin
      cap_err = int'(move_err);
      cap_ok  = int'(move_ok);
    end
    if (busy) run_len++;
    else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(posedge clk); model_clear();
    @(negedge clk); clear = 1'b0;
  endtask

  // One move; optional illegal poke during scan and optional clear mid-scan.
  task automatic do_move(input int p, input int r, input int c,
                         input int poke, input int abort_at);
    int e, s, wl, wv;
    bit aborted;
    @(negedge clk);
    move_req = 1'b1; move_player = PW'(p); move_row = RW'(r); move_col = RW'(c);
    @(posedge clk);
    e = err_of(p, r, c);
    exp_done = 1'b1; exp_ok = (e == 0); exp_err = e; exp_busy = 1'b1;
    if (e == 0) begin
      m_board[r][c] = p;
      m_count++;
`ifdef TURN_ORDER_EN
      m_np = (m_np == NP) ? 1 : m_np + 1;
`endif
    end
    @(negedge clk); move_req = 1'b0;
    @(posedge clk); exp_done = 1'b0;
    if (e != 0) begin
      exp_busy = 1'b0;
      return;
    end
    wl = first_win(wv);
    s = (wl < 0) ? 2 * N + 2 : wl + 1;
    aborted = 1'b0;
    for (int k = 0; k < s; k++) begin
      if (k == abort_at) begin
        @(negedge clk); clear = 1'b1;
        @(posedge clk); model_clear();
        @(negedge clk); clear = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (k == poke) begin
        @(negedge clk);
        move_req = 1'b1; move_player = PW'(1); move_row = RW'(2); move_col = RW'(2);
      end
      @(posedge clk);
      if (k == poke) begin
        @(negedge clk); move_req = 1'b0;
      end
    end
    if (!aborted) begin
      exp_busy = 1'b0;
      if (wl >= 0) begin
        m_winner = wv;
        m_go = 1;
      end else if (m_count == N * N) begin
        m_go = 1;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    model_clear();
    @(posedge clk); @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;

    // First move with an ignored request during the scan.
    do_move(1, 0, 0, 2, -1);
    settle();
    chk("lit_board_first", board, 18'h1);
    chk("lit_count_first", move_count, 1);
    chk("lit_busy_len_no_win", last_run, 9);

    do_move(2, 0, 0, -1, -1);
    settle();
    chk("lit_err_occupied", cap_err, 1);
    chk("lit_count_after_reject", move_count, 1);
    do_move(2, 3, 0, -1, -1);
    settle();
    chk("lit_err_range", cap_err, 2);
    do_move(0, 1, 1, -1, -1);
    settle();
    chk("lit_err_player0", cap_err, 3);
    do_move(3, 1, 1, -1, -1);
    settle();
    chk("lit_err_player3", cap_err, 3);

    // Row-1 win for player 1, scan exits on the second line.
    do_clear();
    do_move(1, 1, 0, -1, -1);
    do_move(2, 0, 0, -1, -1);
    do_move(1, 1, 1, -1, -1);
    do_move(2, 0, 1, -1, -1);
    do_move(1, 1, 2, -1, -1);
    settle();
    chk("lit_winner", winner, 1);
    chk("lit_game_over", game_over, 1);
    chk("lit_busy_len_win_l1", last_run, 3);
    do_move(0, 2, 2, -1, -1);
    settle();
    chk("lit_err_game_over", cap_err, 4);

    // Draw: full board, no line.
    do_clear();
    do_move(1, 0, 0, -1, -1);
    do_move(2, 0, 1, -1, -1);
    do_move(1, 0, 2, -1, -1);
    do_move(2, 1, 1, -1, -1);
    do_move(1, 1, 0, -1, -1);
    do_move(2, 1, 2, -1, -1);
    do_move(1, 2, 1, -1, -1);
    do_move(2, 2, 0, -1, -1);
    do_move(1, 2, 2, -1, -1);
    settle();
    chk("lit_draw_full", full, 1);
    chk("lit_draw_over", game_over, 1);
    chk("lit_draw_winner", winner, 0);
    chk("lit_draw_count", move_count, 9);

    // Clear during a scan of a fresh game.
    do_clear();
    do_move(1, 0, 0, -1, 3);
    settle();
    chk("lit_abort_board", board, 0);
    chk("lit_abort_busy", busy, 0);
    chk("lit_abort_count", move_count, 0);

`ifdef TURN_ORDER_EN
    do_clear();
    settle();
    chk("lit_np_start", next_player, 1);
    do_move(2, 0, 0, -1, -1);
    settle();
    chk("lit_err_turn", cap_err, 5);
    do_move(1, 0, 0, -1, -1);
    settle();
    chk("lit_np_after_p1", next_player, 2);
    do_move(2, 1, 1, -1, -1);
    settle();
    chk("lit_p2_ok", cap_ok, 1);
    chk("lit_np_after_p2", next_player, 1);
`else
    settle();
    chk("lit_np_tied", next_player, 0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/board_move_ctrl.md
Name: board_move_ctrl

Overview:
- Parametrised successor of the tic-tac-toe grid write logic.
- Owns an N x N board and accepts moves over a request/done handshake.
- Rejects illegal moves with an error code.
- After each accepted write, runs a sequential win/draw scan, one line per cycle.
- Sits between the player-input FSM and the display/score logic.

Parameters:
- N, 3, board dimension (N x N cells); legal range 3..8.
- PW, 2, bits per cell or player id; cell value 0 = empty.
- NUM_PLAYERS, 2, count of valid player ids 1..NUM_PLAYERS; must satisfy NUM_PLAYERS < 2**PW.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous new-game request.
- move_req  in  1  one-cycle move strobe; sampled only when busy=0.
- move_player  in  PW  id of the moving player.
- move_row  in  RW=$clog2(N)  target row.
- move_col  in  RW  target column.
- move_done  out  1  one-cycle pulse answering an accepted strobe.
- move_ok  out  1  valid with move_done; 1 = cell written.
- move_err  out  3  valid with move_done; error code (see package).
- busy  out  1  high while DONE or SCAN; move_req is ignored while high.
- board  out  N*N*PW  flattened board; cell (r,c) at bits [(r*N+c)*PW +: PW].
- move_count  out  CW=$clog2(N*N+1)  number of filled cells.
- full  out  1  move_count == N*N.
- winner  out  PW  winning player id; 0 = none.
- game_over  out  1  set on a win or a draw.
- next_player  out  PW  expected mover (used only when turn order is enabled).

Behaviour:
- Reset values: on rst=1 all outputs are 0, except next_player = 1 when TURN_ORDER_EN is defined. State = IDLE.
- clear=1 (with rst=0):
  - Same effect as reset, but only for board, move_count, winner, game_over, next_player and state.
  - Aborts any scan in progress.
  - A move_req in the same cycle is dropped; no move_done is produced.
- States:
  - IDLE: busy=0.
  - DONE: one cycle. Drives the move_done pulse; goes to SCAN on a write, otherwise back to IDLE.
  - SCAN: busy=1; line index L runs 0..2N+1.
- Request handling in IDLE (move_req=1, cycle t): errors are checked in priority order, first match wins:
  1. game_over → ERR_GAME_OVER
  2. move_player==0 or move_player>NUM_PLAYERS → ERR_PLAYER
  3. row>=N or col>=N → ERR_RANGE
  4. (TURN_ORDER_EN only) move_player != next_player → ERR_TURN
  5. cell nonzero → ERR_OCCUPIED
- Accepted move:
  - At t+1: cell = move_player, move_count increments, move_done=1, move_ok=1, move_err=ERR_NONE.
  - Then SCAN starts at t+2.
- Rejected move:
  - At t+1: move_done=1, move_ok=0, move_err=code.
  - Board unchanged; returns to IDLE at t+2.
- Scan line order, one line per cycle:
  - L=0..N-1: rows.
  - L=N..2N-1: columns.
  - L=2N: main diagonal.
  - L=2N+1: anti-diagonal.
- Win detection: a line whose N cells are all equal and nonzero registers winner = that value and game_over=1, then returns to IDLE immediately (early exit).
- End of scan with no win: if full=1, set game_over=1 with winner=0 (draw). Return to IDLE.
- Worst-case busy duration after a move: 1 + (2N+2) cycles.
- move_count saturates at N*N; full keeps it from being exceeded.

Optional Feature:
- Macro: TURN_ORDER_EN.
- Defined:
  - next_player resets/clears to 1.
  - next_player advances on each accepted move (1..NUM_PLAYERS, wrapping to 1).
  - A wrong mover is rejected with ERR_TURN.
- Undefined:
  - No turn check; next_player is tied to 0.
  - ERR_TURN is never produced.

Decomposition:
- Package board_pkg:
  - move_err codes: ERR_NONE=0, ERR_OCCUPIED=1, ERR_RANGE=2, ERR_PLAYER=3, ERR_GAME_OVER=4, ERR_TURN=5.
  - FSM state encoding: IDLE, DONE, SCAN.
  - Localparam helpers for RW, CW and line count 2N+2.
- Sub-module board_line_check (combinational):
  - Inputs: board, line index L.
  - Outputs: line_win (1 bit) and line_val (PW).
  - Isolates the row/column/diagonal indexing from the FSM.

Test Plan:
- rst, then move p1 at (0,0) → move_done at t+1 with move_ok=1; board[1:0]=1; move_count=1; busy for 9 cycles (N=3, no win).
- Repeat move p2 at (0,0) → move_ok=0, move_err=1 (ERR_OCCUPIED); board unchanged; move_count=1.
- move_row=3, then move_player=0 → ERR_RANGE (2), then ERR_PLAYER (3); no state change.
- p1 fills row 1 (p2 interleaved on row 0) → after scan, winner=1, game_over=1, scan exits at L=1; next move → ERR_GAME_OVER (4).
- Fill all 9 cells with no line → full=1, game_over=1, winner=0; then clear asserted mid-scan of a fresh game → next cycle board=0, busy=0, move_count=0.
- TURN_ORDER_EN defined: p2 moves first → ERR_TURN (5); p1 then p2 → both ok; next_player sequence 1→2→1.
